// File: rtl/lc3_regfile_sb_if.sv
// lc3_regfile_sb_if: write/reserve/read bundle for the scoreboarded register file.
interface lc3_regfile_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_set_cc;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic              rd1_busy;
  logic              rd2_busy;
  logic [NUM_REGS-1:0] busy_vec;
  logic [2:0]        nzp;
  logic [DATA_W-1:0] dbg_reg;
  modport master (
    output wr_en, wr_addr, wr_data, wr_set_cc, rsv_en, rsv_addr, rd1_addr, rd2_addr,
    input  rd1_data, rd2_data, rd1_busy, rd2_busy, busy_vec, nzp, dbg_reg
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_set_cc, rsv_en, rsv_addr, rd1_addr, rd2_addr,
    output rd1_data, rd2_data, rd1_busy, rd2_busy, busy_vec, nzp, dbg_reg
  );
endinterface

// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb: LC-3 style register file with write-through reads, busy scoreboard and NZP flags.
module lc3_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int DBG_REG  = 0
) (
  input logic clock,
  input logic reset,
  lc3_regfile_sb_if.slave sb
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_REG);
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, dbg_q, dbg_d;
  logic                rd1_busy_q, rd1_busy_d, rd2_busy_q, rd2_busy_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          nzp_q, nzp_d;
  logic                hit1, hit2, hitd;
  // Reservation is applied after the writeback clear so a same-cycle reissue stays busy.
  always_comb begin
    hit1       = sb.wr_en && sb.wr_addr == sb.rd1_addr;
    hit2       = sb.wr_en && sb.wr_addr == sb.rd2_addr;
    hitd       = sb.wr_en && sb.wr_addr == DBG_A;
    rd1_d      = hit1 ? sb.wr_data : mem_q[sb.rd1_addr];
    rd2_d      = hit2 ? sb.wr_data : mem_q[sb.rd2_addr];
    dbg_d      = hitd ? sb.wr_data : mem_q[DBG_A];
    busy_d     = (busy_q & ~(NUM_REGS'(sb.wr_en) << sb.wr_addr)) | (NUM_REGS'(sb.rsv_en) << sb.rsv_addr);
    rd1_busy_d = busy_d[sb.rd1_addr];
    rd2_busy_d = busy_d[sb.rd2_addr];
    nzp_d      = !(sb.wr_en && sb.wr_set_cc) ? nzp_q :
                 sb.wr_data[DATA_W-1]        ? 3'b100 :
                 ~|sb.wr_data                ? 3'b010 : 3'b001;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      dbg_q      <= '0;
      rd1_busy_q <= 1'b0;
      rd2_busy_q <= 1'b0;
      busy_q     <= '0;
      nzp_q      <= 3'b010;
    end else begin
      if (sb.wr_en) mem_q[sb.wr_addr] <= sb.wr_data;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      dbg_q      <= dbg_d;
      rd1_busy_q <= rd1_busy_d;
      rd2_busy_q <= rd2_busy_d;
      busy_q     <= busy_d;
      nzp_q      <= nzp_d;
    end
  end
  assign sb.rd1_data = rd1_q;
  assign sb.rd2_data = rd2_q;
  assign sb.rd1_busy = rd1_busy_q;
  assign sb.rd2_busy = rd2_busy_q;
  assign sb.busy_vec = busy_q;
  assign sb.nzp      = nzp_q;
  assign sb.dbg_reg  = dbg_q;
endmodule

// File: tb/tb_lc3_regfile_sb.sv
// tb_lc3_regfile_sb: two configurations driven in lockstep and checked against an array model.
module tb_lc3_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lc3_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8))  ifa ();
  lc3_regfile_sb_if #(.DATA_W(32), .NUM_REGS(16)) ifb ();
  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8),  .DBG_REG(0))  dut_a (.clock(clk), .reset(rst), .sb(ifa));
  lc3_regfile_sb #(.DATA_W(32), .NUM_REGS(16), .DBG_REG(15)) dut_b (.clock(clk), .reset(rst), .sb(ifb));
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_m [2][16];
  logic [15:0] busy_m [2];
  logic [2:0]  nzp_m [2];
  logic [31:0] e_rd1 [2], e_rd2 [2], e_dbg [2];
  logic        e_b1 [2], e_b2 [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rs, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                      input bit cc, input bit rv, input logic [3:0] ra,
                      input logic [3:0] r1, input logic [3:0] r2);
    int m, msb, dbg;
    logic [31:0] d;
    rst = rs;
    ifa.wr_en = we; ifa.wr_addr = wa[2:0]; ifa.wr_data = wd[15:0]; ifa.wr_set_cc = cc;
    ifa.rsv_en = rv; ifa.rsv_addr = ra[2:0]; ifa.rd1_addr = r1[2:0]; ifa.rd2_addr = r2[2:0];
    ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.wr_set_cc = cc;
    ifb.rsv_en = rv; ifb.rsv_addr = ra; ifb.rd1_addr = r1; ifb.rd2_addr = r2;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      m   = c == 0 ? 7 : 15;
      msb = c == 0 ? 15 : 31;
      dbg = c == 0 ? 0 : 15;
      d   = c == 0 ? (wd & 32'hFFFF) : wd;
      if (rs) begin
        for (int i = 0; i < 16; i++) mem_m[c][i] = '0;
        busy_m[c] = '0;
        nzp_m[c]  = 3'b010;
        e_rd1[c] = '0; e_rd2[c] = '0; e_dbg[c] = '0; e_b1[c] = 1'b0; e_b2[c] = 1'b0;
      end else begin
        if (we) begin
          mem_m[c][wa & m] = d;
          busy_m[c][wa & m] = 1'b0;
          if (cc) nzp_m[c] = d[msb] ? 3'b100 : (d == 0 ? 3'b010 : 3'b001);
        end
        if (rv) busy_m[c][ra & m] = 1'b1;
        e_rd1[c] = mem_m[c][r1 & m];
        e_rd2[c] = mem_m[c][r2 & m];
        e_b1[c]  = busy_m[c][r1 & m];
        e_b2[c]  = busy_m[c][r2 & m];
        e_dbg[c] = mem_m[c][dbg];
      end
    end
    chk("a_rd1", ifa.rd1_data, e_rd1[0]);
    chk("a_rd2", ifa.rd2_data, e_rd2[0]);
    chk("a_b1", ifa.rd1_busy, e_b1[0]);
    chk("a_b2", ifa.rd2_busy, e_b2[0]);
    chk("a_bv", ifa.busy_vec, busy_m[0] & 16'hFF);
    chk("a_nzp", ifa.nzp, nzp_m[0]);
    chk("a_dbg", ifa.dbg_reg, e_dbg[0]);
    chk("b_rd1", ifb.rd1_data, e_rd1[1]);
    chk("b_rd2", ifb.rd2_data, e_rd2[1]);
    chk("b_b1", ifb.rd1_busy, e_b1[1]);
    chk("b_b2", ifb.rd2_busy, e_b2[1]);
    chk("b_bv", ifb.busy_vec, busy_m[1]);
    chk("b_nzp", ifb.nzp, nzp_m[1]);
    chk("b_dbg", ifb.dbg_reg, e_dbg[1]);
  endtask
  initial begin
    logic [3:0] wa, ra, r1, r2;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(7 - i));
    chk("rst_nzp", ifa.nzp, 3'b010);
    chk("rst_bv", ifa.busy_vec, 0);
    step(0, 1, 3, 32'h1234, 1, 0, 0, 3, 0);
    chk("r3_byp", ifa.rd1_data, 16'h1234);
    chk("nzp_p", ifa.nzp, 3'b001);
    step(0, 1, 5, 32'h8000, 1, 0, 0, 3, 3);
    chk("r3_rd", ifa.rd2_data, 16'h1234);
    chk("nzp_n", ifa.nzp, 3'b100);
    step(0, 1, 5, 0, 0, 0, 0, 5, 5);
    chk("nzp_hold", ifa.nzp, 3'b100);
    step(0, 1, 2, 32'hBEEF, 0, 0, 0, 2, 2);
    chk("byp1", ifa.rd1_data, 16'hBEEF);
    chk("byp2", ifa.rd2_data, 16'hBEEF);
    step(0, 0, 0, 0, 0, 1, 4, 4, 4);
    chk("rsv_bv", ifa.busy_vec, 8'h10);
    chk("rsv_b1", ifa.rd1_busy, 1);
    step(0, 1, 4, 7, 0, 0, 0, 4, 4);
    chk("wb_bv", ifa.busy_vec, 0);
    chk("wb_b1", ifa.rd1_busy, 0);
    step(0, 1, 4, 9, 0, 1, 4, 4, 4);
    chk("both_bv", ifa.busy_vec, 8'h10);
    chk("both_rd", ifa.rd1_data, 9);
    step(1, 1, 1, 32'hFFFF, 1, 1, 1, 1, 1);
    chk("rstw_bv", ifa.busy_vec, 0);
    chk("rstw_nzp", ifa.nzp, 3'b010);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("rstw_r1", ifa.rd1_data, 0);
    step(0, 1, 15, 32'h8000_0001, 1, 0, 0, 15, 15);
    chk("b_dbg15", ifb.dbg_reg, 32'h8000_0001);
    chk("b_nzp_n", ifb.nzp, 3'b100);
    for (int n = 0; n < 500; n++) begin
      wa = 4'($urandom);
      ra = $urandom_range(0, 3) == 0 ? wa : 4'($urandom);
      r1 = $urandom_range(0, 2) == 0 ? wa : 4'($urandom);
      r2 = $urandom_range(0, 2) == 0 ? ra : 4'($urandom);
      step($urandom_range(0, 40) == 0, 1'($urandom), wa,
           $urandom_range(0, 5) == 0 ? 32'h0 : $urandom, 1'($urandom),
           1'($urandom), ra, r1, r2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
